// File: rtl/nn_train_sequencer_if.sv
// Bundle between the training sequencer (master) and its dataset loader / NN core side (slave).
interface nn_train_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int EPOCH_W = 16
);
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic signed [DATA_W-1:0]  wr_x1;
  logic signed [DATA_W-1:0]  wr_x2;
  logic signed [DATA_W-1:0]  wr_t1;
  logic signed [DATA_W-1:0]  wr_t2;
  logic                      start;
  logic                      abort;
  logic                      finish_updating;
  logic                      update_coeff;
  logic signed [DATA_W-1:0]  input_k_1;
  logic signed [DATA_W-1:0]  input_k_2;
  logic signed [DATA_W-1:0]  target_1;
  logic signed [DATA_W-1:0]  target_2;
  logic [ADDR_W-1:0]         sample_idx;
  logic [EPOCH_W-1:0]        epoch_cnt;
  logic                      busy;
  logic                      done;

  modport master (
    input  wr_en, wr_addr, wr_x1, wr_x2, wr_t1, wr_t2, start, abort, finish_updating,
    output update_coeff, input_k_1, input_k_2, target_1, target_2,
           sample_idx, epoch_cnt, busy, done
  );

  modport slave (
    output wr_en, wr_addr, wr_x1, wr_x2, wr_t1, wr_t2, start, abort, finish_updating,
    input  update_coeff, input_k_1, input_k_2, target_1, target_2,
           sample_idx, epoch_cnt, busy, done
  );
endinterface

// File: rtl/nn_train_sequencer.sv
// Steps an NN core through a stored training set for MAX_EPOCH epochs; start->update_coeff 2 cycles,
// finish_updating->next update_coeff 3 cycles; holds each sample until the core reports finish_updating.
module nn_train_sequencer #(
  parameter int DATA_W    = 16,
  parameter int N_SAMPLES = 4,
  parameter int ADDR_W    = 2,
  parameter int EPOCH_W   = 16,
  parameter int MAX_EPOCH = 10000
) (
  input  logic                 clk,
  input  logic                 res,
  nn_train_sequencer_if.master bus
);

  typedef struct packed {
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] t1;
    logic signed [DATA_W-1:0] t2;
  } sample_t;

  typedef enum logic [2:0] {IDLE, SETUP, UPDATE, ADVANCE, DONE} state_t;

  state_t             state;
  sample_t            mem [N_SAMPLES];
  sample_t            rd_sample;
  logic               idle_or_done;
  logic               last_sample;
  logic [EPOCH_W-1:0] epoch_nxt;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign last_sample  = (bus.sample_idx == ADDR_W'(N_SAMPLES - 1));
  assign epoch_nxt    = bus.epoch_cnt + EPOCH_W'(1);
  assign rd_sample    = mem[bus.sample_idx];

  // Dataset survives reset so a re-start replays the previously loaded set.
  always_ff @(posedge clk) begin
    if (bus.wr_en && idle_or_done) begin
      mem[bus.wr_addr] <= '{x1: bus.wr_x1, x2: bus.wr_x2, t1: bus.wr_t1, t2: bus.wr_t2};
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state            <= IDLE;
      bus.update_coeff <= 1'b0;
      bus.input_k_1    <= '0;
      bus.input_k_2    <= '0;
      bus.target_1     <= '0;
      bus.target_2     <= '0;
      bus.sample_idx   <= '0;
      bus.epoch_cnt    <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else if (bus.abort) begin
      // Position and presented data are kept so the interrupted point stays visible.
      state            <= IDLE;
      bus.update_coeff <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state          <= SETUP;
            bus.sample_idx <= '0;
            bus.epoch_cnt  <= '0;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
          end
        end
        SETUP: begin
          bus.input_k_1    <= rd_sample.x1;
          bus.input_k_2    <= rd_sample.x2;
          bus.target_1     <= rd_sample.t1;
          bus.target_2     <= rd_sample.t2;
          bus.update_coeff <= 1'b1;
          state            <= UPDATE;
        end
        UPDATE: begin
          if (bus.finish_updating) begin
            bus.update_coeff <= 1'b0;
            state            <= ADVANCE;
          end
        end
        ADVANCE: begin
          // N_SAMPLES is a power of two, so the index wraps naturally.
          bus.sample_idx <= bus.sample_idx + ADDR_W'(1);
          if (last_sample) begin
            bus.epoch_cnt <= epoch_nxt;
            if (epoch_nxt == EPOCH_W'(MAX_EPOCH)) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end else begin
            state <= SETUP;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
